// File: rtl/control_multi.sv
// control_multi: multicycle control FSM for the riscy32 core.
//
// Steps each RV32I instruction through FETCH / DECODE / execute / writeback
// states. It also provides:
//   - a memory ready/wait handshake with a bounded wait-state timeout,
//   - an illegal-opcode trap,
//   - full branch-condition and ALU-operation decode.
//
// Parameters:
//   MAX_WAIT  consecutive wait cycles a memory state tolerates (1..255)
//   WAIT_W    width of the wait counter; 2**WAIT_W must exceed MAX_WAIT
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   op, funct3, funct7  instruction fields IR[6:0], IR[14:12], IR[30]
//   flags               ALU flags {N,Z,C,V}; C=1 means no borrow on SUB
//   mem_ready           memory completes the current access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
//                       datapath controls
//   trap, trap_cause    sticky fault flag and cause (01 illegal, 10 timeout)
//   state               current FSM state (debug)
//
// Optional feature (macro CONTROL_MULTI_PERF_EN) adds two outputs:
//   cycle_cnt    counts every cycle outside TRAP
//   instret_cnt  counts completed instructions
module control_multi #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7,
    input  logic [3:0]  flags,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [3:0]  state
`ifdef CONTROL_MULTI_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    typedef enum logic [3:0] {
        FETCH      = 4'd0,
        DECODE     = 4'd1,
        MEMADR     = 4'd2,
        MEMREAD    = 4'd3,
        MEMWB      = 4'd4,
        MEMWRITE   = 4'd5,
        EXEC_R     = 4'd6,
        EXEC_I     = 4'd7,
        EXEC_LUI   = 4'd8,
        EXEC_AUIPC = 4'd9,
        ALUWB      = 4'd10,
        BRANCH     = 4'd11,
        JAL        = 4'd12,
        JALR       = 4'd13,
        TRAP       = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    state_t            cur_state;
    state_t            nxt_state;
    logic [1:0]        nxt_cause;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_wait;
    logic              timeout;
    logic              taken;
    logic              pc_w;
    logic              ir_w;
    logic              mem_w;
    logic              reg_w;

    // alt selects SUB for funct3=000 and SRA for funct3=101.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
        logic [3:0] res;
        case (f3)
            3'b000:  res = alt ? ALU_SUB : ALU_ADD;
            3'b001:  res = ALU_SLL;
            3'b010:  res = ALU_SLT;
            3'b011:  res = ALU_SLTU;
            3'b100:  res = ALU_XOR;
            3'b101:  res = alt ? ALU_SRA : ALU_SRL;
            3'b110:  res = ALU_OR;
            default: res = ALU_AND;
        endcase
        return res;
    endfunction

    assign mem_wait = (cur_state == FETCH) || (cur_state == MEMREAD) || (cur_state == MEMWRITE);
    // Completion in the same cycle the limit is reached takes priority over the timeout.
    assign timeout  = mem_wait && !mem_ready && (wait_cnt == WAIT_LIMIT);

    // Branch condition from the flags of rs1 - rs2 computed in BRANCH.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = flags[2];
            3'b001:  taken = !flags[2];
            3'b100:  taken = flags[3] ^ flags[0];
            3'b101:  taken = !(flags[3] ^ flags[0]);
            3'b110:  taken = !flags[1];
            3'b111:  taken = flags[1];
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        nxt_state = cur_state;
        nxt_cause = 2'b00;
        case (cur_state)
            FETCH: begin
                if (mem_ready) begin
                    nxt_state = DECODE;
                end else if (timeout) begin
                    nxt_state = TRAP;
                    nxt_cause = 2'b10;
                end
            end
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: nxt_state = MEMADR;
                    OP_R:              nxt_state = EXEC_R;
                    OP_I:              nxt_state = EXEC_I;
                    OP_BRANCH:         nxt_state = BRANCH;
                    OP_JAL:            nxt_state = JAL;
                    OP_JALR:           nxt_state = JALR;
                    OP_LUI:            nxt_state = EXEC_LUI;
                    OP_AUIPC:          nxt_state = EXEC_AUIPC;
                    default: begin
                        nxt_state = TRAP;
                        nxt_cause = 2'b01;
                    end
                endcase
            end
            MEMADR: nxt_state = (op == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD: begin
                if (mem_ready) begin
                    nxt_state = MEMWB;
                end else if (timeout) begin
                    nxt_state = TRAP;
                    nxt_cause = 2'b10;
                end
            end
            MEMWRITE: begin
                if (mem_ready) begin
                    nxt_state = FETCH;
                end else if (timeout) begin
                    nxt_state = TRAP;
                    nxt_cause = 2'b10;
                end
            end
            MEMWB, ALUWB, BRANCH: nxt_state = FETCH;
            EXEC_R, EXEC_I, EXEC_LUI, EXEC_AUIPC: nxt_state = ALUWB;
            // JAL writes PC from ALUOut and computes the link (OldPC+4) into ALUOut.
            JAL:  nxt_state = ALUWB;
            JALR: nxt_state = JAL;
            TRAP: nxt_state = TRAP;
            default: nxt_state = TRAP;
        endcase
    end

    always_comb begin
        pc_w       = 1'b0;
        ir_w       = 1'b0;
        mem_w      = 1'b0;
        reg_w      = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 3'b000;
        ALUControl = ALU_ADD;
        case (cur_state)
            FETCH: begin
                ir_w      = mem_ready;
                pc_w      = mem_ready;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                // The target precomputed here must use the immediate format of the op.
                if (op == OP_BRANCH) begin
                    ImmSrc = 3'b010;
                end else if (op == OP_JAL) begin
                    ImmSrc = 3'b011;
                end
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_STORE) ? 3'b001 : 3'b000;
            end
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            EXEC_R: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_decode(funct3, funct7);
            end
            EXEC_I: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                // Bit 30 is part of the immediate except for the shift-right variants.
                ALUControl = alu_decode(funct3, funct7 && (funct3 == 3'b101));
            end
            EXEC_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b100;
            end
            EXEC_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b100;
            end
            ALUWB: reg_w = 1'b1;
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                ImmSrc     = 3'b010;
                pc_w       = taken;
            end
            JAL: begin
                ImmSrc  = 3'b011;
                pc_w    = 1'b1;
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
            end
            JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            default: ;
        endcase
    end

    // Enables are forced low during reset even though FETCH would follow mem_ready.
    assign PCWrite  = pc_w  & rst_n;
    assign IRWrite  = ir_w  & rst_n;
    assign MemWrite = mem_w & rst_n;
    assign RegWrite = reg_w & rst_n;
    assign state    = cur_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state  <= FETCH;
            wait_cnt   <= '0;
            trap       <= 1'b0;
            trap_cause <= 2'b00;
`ifdef CONTROL_MULTI_PERF_EN
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
`endif
        end else begin
            cur_state <= nxt_state;
            if (nxt_state != cur_state) begin
                wait_cnt <= '0;
            end else if (mem_wait && !mem_ready && (wait_cnt != WAIT_LIMIT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if ((nxt_state == TRAP) && (cur_state != TRAP)) begin
                trap       <= 1'b1;
                trap_cause <= nxt_cause;
            end
`ifdef CONTROL_MULTI_PERF_EN
            if (cur_state != TRAP) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if ((cur_state != FETCH) && (nxt_state == FETCH)) begin
                instret_cnt <= instret_cnt + 32'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_control_multi.sv
// tb_control_multi: directed, scoreboard-checked bench for control_multi.
// Each cycle pushes the expected control word and state, then pops and
// compares it against the DUT half a cycle later.
module tb_control_multi;

    localparam logic [3:0] S_FETCH      = 4'd0;
    localparam logic [3:0] S_DECODE     = 4'd1;
    localparam logic [3:0] S_MEMADR     = 4'd2;
    localparam logic [3:0] S_MEMREAD    = 4'd3;
    localparam logic [3:0] S_MEMWB      = 4'd4;
    localparam logic [3:0] S_MEMWRITE   = 4'd5;
    localparam logic [3:0] S_EXEC_R     = 4'd6;
    localparam logic [3:0] S_EXEC_I     = 4'd7;
    localparam logic [3:0] S_EXEC_LUI   = 4'd8;
    localparam logic [3:0] S_EXEC_AUIPC = 4'd9;
    localparam logic [3:0] S_ALUWB      = 4'd10;
    localparam logic [3:0] S_BRANCH     = 4'd11;
    localparam logic [3:0] S_JAL        = 4'd12;
    localparam logic [3:0] S_JALR       = 4'd13;
    localparam logic [3:0] S_TRAP       = 4'd14;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic       regw;
        logic [1:0] rsrc;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [2:0] imm;
        logic [3:0] aluc;
        logic       trp;
        logic [1:0] cause;
    } exp_t;

    typedef struct {
        logic [2:0] f3;
        logic [3:0] fl;
        logic       tk;
    } br_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  op = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        funct7 = 1'b0;
    logic [3:0]  flags = 4'd0;
    logic        mem_ready = 1'b0;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ImmSrc;
    logic [3:0]  ALUControl;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [3:0]  state;
`ifdef CONTROL_MULTI_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    int         checks = 0;
    int         failures = 0;
    exp_t       sb_q[$];
    string      tag_q[$];
    logic [3:0] x_aluc = 4'd0;
    logic       x_taken = 1'b0;
    logic [1:0] x_cause = 2'b00;

    control_multi #(.MAX_WAIT(15), .WAIT_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .op(op),
        .funct3(funct3),
        .funct7(funct7),
        .flags(flags),
        .mem_ready(mem_ready),
        .PCWrite(PCWrite),
        .AdrSrc(AdrSrc),
        .MemWrite(MemWrite),
        .IRWrite(IRWrite),
        .RegWrite(RegWrite),
        .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc),
        .ALUControl(ALUControl),
        .trap(trap),
        .trap_cause(trap_cause),
        .state(state)
`ifdef CONTROL_MULTI_PERF_EN
        ,
        .cycle_cnt(cycle_cnt),
        .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Expected outputs for a state, taken from the state table of the control unit.
    function automatic exp_t expected_for(input logic [3:0] st, input logic mr);
        exp_t e;
        e = '0;
        e.st = st;
        case (st)
            S_FETCH:      begin e.irw = mr; e.pcw = mr; e.srcb = 2'b10; e.rsrc = 2'b10; end
            S_DECODE:     begin
                e.srca = 2'b01; e.srcb = 2'b01;
                e.imm = (op == 7'b1100011) ? 3'b010 : (op == 7'b1101111) ? 3'b011 : 3'b000;
            end
            S_MEMADR:     begin e.srca = 2'b10; e.srcb = 2'b01; e.imm = (op == 7'b0100011) ? 3'b001 : 3'b000; end
            S_MEMREAD:    e.adr = 1'b1;
            S_MEMWB:      begin e.rsrc = 2'b01; e.regw = 1'b1; end
            S_MEMWRITE:   begin e.adr = 1'b1; e.memw = 1'b1; end
            S_EXEC_R:     begin e.srca = 2'b10; e.aluc = x_aluc; end
            S_EXEC_I:     begin e.srca = 2'b10; e.srcb = 2'b01; e.aluc = x_aluc; end
            S_EXEC_LUI:   begin e.srca = 2'b11; e.srcb = 2'b01; e.imm = 3'b100; end
            S_EXEC_AUIPC: begin e.srca = 2'b01; e.srcb = 2'b01; e.imm = 3'b100; end
            S_ALUWB:      e.regw = 1'b1;
            S_BRANCH:     begin e.srca = 2'b10; e.aluc = 4'd1; e.imm = 3'b010; e.pcw = x_taken; end
            S_JAL:        begin e.imm = 3'b011; e.pcw = 1'b1; e.srca = 2'b01; e.srcb = 2'b10; end
            S_JALR:       begin e.srca = 2'b10; e.srcb = 2'b01; end
            S_TRAP:       begin e.trp = 1'b1; e.cause = x_cause; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o = {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ImmSrc, ALUControl, trap, trap_cause};
        return o;
    endfunction

    task automatic applyStimulus(input string tag, input logic [3:0] st, input logic mr);
        mem_ready = mr;
        sb_q.push_back(expected_for(st, mr));
        tag_q.push_back(tag);
    endtask

    task automatic checkOutput();
        exp_t  e;
        exp_t  o;
        string t;
        checks++;
        assert (sb_q.size() != 0) else begin
            failures++;
            $error("[TB] FAIL sb_empty observed=0 entries required=1 entry");
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            o = observed();
            assert (o === e) else begin
                failures++;
                $error("[TB] FAIL %s observed=%h expected=%h (state %0d vs %0d)", t, o, e, o.st, e.st);
            end
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] st, input logic mr);
        applyStimulus(tag, st, mr);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input string tag);
        exp_t o;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        o = observed();
        checks++;
        assert ((o.st === S_FETCH) && (o.trp === 1'b0) && (o.cause === 2'b00) &&
                ({o.pcw, o.memw, o.irw, o.regw} === 4'b0000)) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=state 0, enables 0, trap 0", tag, o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic setInstr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o;
        funct3 = f3;
        funct7 = f7;
    endtask

    task automatic runAlu(input string t, input logic [6:0] o, input logic [2:0] f3,
                          input logic f7, input logic [3:0] aluc, input logic [3:0] ex);
        setInstr(o, f3, f7);
        x_aluc = aluc;
        cyc({t, "_fetch"}, S_FETCH, 1'b1);
        cyc({t, "_decode"}, S_DECODE, 1'b1);
        cyc({t, "_exec"}, ex, 1'b1);
        cyc({t, "_wb"}, S_ALUWB, 1'b1);
    endtask

    initial begin
        br_t br_tab[$];
        $display("[TB] starting control_multi bench");
        doReset("reset_initial");

        // add, sub vs srai, shifts, logic ops.
        runAlu("add",  7'b0110011, 3'b000, 1'b0, 4'd0, S_EXEC_R);
        runAlu("sub",  7'b0110011, 3'b000, 1'b1, 4'd1, S_EXEC_R);
        runAlu("addi_f7", 7'b0010011, 3'b000, 1'b1, 4'd0, S_EXEC_I);
        runAlu("sra",  7'b0110011, 3'b101, 1'b1, 4'd7, S_EXEC_R);
        runAlu("srai", 7'b0010011, 3'b101, 1'b1, 4'd7, S_EXEC_I);
        runAlu("srli", 7'b0010011, 3'b101, 1'b0, 4'd6, S_EXEC_I);
        runAlu("and",  7'b0110011, 3'b111, 1'b0, 4'd9, S_EXEC_R);
        runAlu("ori",  7'b0010011, 3'b110, 1'b0, 4'd8, S_EXEC_I);
        runAlu("sltu", 7'b0110011, 3'b011, 1'b0, 4'd4, S_EXEC_R);
        runAlu("lui",  7'b0110111, 3'b000, 1'b0, 4'd0, S_EXEC_LUI);
        runAlu("auipc", 7'b0010111, 3'b000, 1'b0, 4'd0, S_EXEC_AUIPC);

        // lw with three wait cycles in MEMREAD.
        setInstr(7'b0000011, 3'b010, 1'b0);
        cyc("lw_fetch", S_FETCH, 1'b1);
        cyc("lw_decode", S_DECODE, 1'b1);
        cyc("lw_memadr", S_MEMADR, 1'b1);
        for (int i = 0; i < 3; i++) cyc("lw_memread_wait", S_MEMREAD, 1'b0);
        cyc("lw_memread_done", S_MEMREAD, 1'b1);
        cyc("lw_memwb", S_MEMWB, 1'b1);

        // sw with one wait cycle.
        setInstr(7'b0100011, 3'b010, 1'b0);
        cyc("sw_fetch", S_FETCH, 1'b1);
        cyc("sw_decode", S_DECODE, 1'b1);
        cyc("sw_memadr", S_MEMADR, 1'b1);
        cyc("sw_memwrite_wait", S_MEMWRITE, 1'b0);
        cyc("sw_memwrite_done", S_MEMWRITE, 1'b1);

        // jal and jalr.
        setInstr(7'b1101111, 3'b000, 1'b0);
        cyc("jal_fetch", S_FETCH, 1'b1);
        cyc("jal_decode", S_DECODE, 1'b1);
        cyc("jal_jump", S_JAL, 1'b1);
        cyc("jal_wb", S_ALUWB, 1'b1);
        setInstr(7'b1100111, 3'b000, 1'b0);
        cyc("jalr_fetch", S_FETCH, 1'b1);
        cyc("jalr_decode", S_DECODE, 1'b1);
        cyc("jalr_calc", S_JALR, 1'b1);
        cyc("jalr_jump", S_JAL, 1'b1);
        cyc("jalr_wb", S_ALUWB, 1'b1);

        // Branch table: flags {N,Z,C,V}, expected taken worked out per condition.
        br_tab = '{
            '{3'b000, 4'b0100, 1'b1}, '{3'b001, 4'b0100, 1'b0}, '{3'b100, 4'b0100, 1'b0},
            '{3'b101, 4'b0100, 1'b1}, '{3'b110, 4'b0100, 1'b1}, '{3'b111, 4'b0100, 1'b0},
            '{3'b000, 4'b1000, 1'b0}, '{3'b001, 4'b1000, 1'b1}, '{3'b100, 4'b1000, 1'b1},
            '{3'b101, 4'b1000, 1'b0}, '{3'b000, 4'b0000, 1'b0}, '{3'b001, 4'b0000, 1'b1},
            '{3'b100, 4'b0000, 1'b0}, '{3'b101, 4'b0000, 1'b1}, '{3'b110, 4'b0000, 1'b1},
            '{3'b111, 4'b0000, 1'b0}, '{3'b110, 4'b0010, 1'b0}, '{3'b111, 4'b0010, 1'b1},
            '{3'b100, 4'b1001, 1'b0}, '{3'b101, 4'b1001, 1'b1}, '{3'b100, 4'b0001, 1'b1},
            '{3'b010, 4'b0100, 1'b0}, '{3'b011, 4'b1111, 1'b0}
        };
        foreach (br_tab[i]) begin
            setInstr(7'b1100011, br_tab[i].f3, 1'b0);
            flags = br_tab[i].fl;
            x_taken = br_tab[i].tk;
            cyc($sformatf("br%0d_fetch", i), S_FETCH, 1'b1);
            cyc($sformatf("br%0d_decode", i), S_DECODE, 1'b1);
            cyc($sformatf("br%0d_branch_f3_%0d_fl_%b", i, br_tab[i].f3, br_tab[i].fl), S_BRANCH, 1'b1);
        end

        // Illegal opcode traps and holds with all enables low.
        setInstr(7'b1111111, 3'b000, 1'b0);
        x_cause = 2'b01;
        cyc("ill_fetch", S_FETCH, 1'b1);
        cyc("ill_decode", S_DECODE, 1'b1);
        for (int i = 0; i < 20; i++) cyc($sformatf("ill_trap%0d", i), S_TRAP, 1'b1);
        doReset("reset_after_illegal");
        setInstr(7'b0110011, 3'b000, 1'b0);
        x_aluc = 4'd0;
        cyc("post_ill_fetch", S_FETCH, 1'b1);
        cyc("post_ill_decode", S_DECODE, 1'b1);
        cyc("post_ill_exec", S_EXEC_R, 1'b1);
        cyc("post_ill_wb", S_ALUWB, 1'b1);

        // Fetch timeout: 15 counted wait cycles, then the next idle cycle traps.
        doReset("reset_before_timeout");
        x_cause = 2'b10;
        for (int i = 0; i < 16; i++) cyc($sformatf("to_wait%0d", i), S_FETCH, 1'b0);
        cyc("to_trap0", S_TRAP, 1'b0);
        cyc("to_trap1", S_TRAP, 1'b1);

        // Same wait, but memory answers on the deciding cycle: no trap.
        doReset("reset_before_edge");
        for (int i = 0; i < 15; i++) cyc($sformatf("edge_wait%0d", i), S_FETCH, 1'b0);
        cyc("edge_ready", S_FETCH, 1'b1);
        cyc("edge_decode", S_DECODE, 1'b1);
        cyc("edge_exec", S_EXEC_R, 1'b1);
        cyc("edge_wb", S_ALUWB, 1'b1);

        // Reset in the middle of a store abandons the write.
        setInstr(7'b0100011, 3'b000, 1'b0);
        cyc("mid_fetch", S_FETCH, 1'b1);
        cyc("mid_decode", S_DECODE, 1'b1);
        cyc("mid_memadr", S_MEMADR, 1'b1);
        cyc("mid_memwrite", S_MEMWRITE, 1'b0);
        mem_ready = 1'b0;
        doReset("reset_mid_store");
        setInstr(7'b0110011, 3'b000, 1'b0);
        cyc("after_mid_fetch", S_FETCH, 1'b1);
        cyc("after_mid_decode", S_DECODE, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
